// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART handshake bundle for uart_tx_arbiter.
// master = requesters plus UART model side, slave = arbiter side.
interface uart_tx_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        timeout_err;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_data, tx_start, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_data, tx_start, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among 4 requesters.
// Optional stall timeout that revokes a grant is built only with UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANTED   = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e      state_q;
  logic [3:0]  grant_q;
  logic [1:0]  owner_q;
  logic [1:0]  rr_ptr_q;
  logic [7:0]  tx_data_q;
  logic        tx_start_q;
  logic        last_flag_q;

  logic [1:0]  pick_c;
  logic        pick_vld_c;
  logic [3:0]  ready_c;
  logic        xfer_c;
  logic        owner_vld_c;

  // First valid requester at or after rr_ptr; lowest offset is written last so it wins.
  always_comb begin
    pick_c     = rr_ptr_q;
    pick_vld_c = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req_valid[rr_ptr_q + 2'(k)]) begin
        pick_c     = rr_ptr_q + 2'(k);
        pick_vld_c = 1'b1;
      end
    end
  end

  assign ready_c     = (state_q == GRANTED && !bus.tx_busy) ? (grant_q & bus.req_valid) : 4'b0000;
  assign xfer_c      = |ready_c;
  assign owner_vld_c = bus.req_valid[owner_q];

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             timeout_err_q;
`else
  logic unused_tmo_param;
  assign unused_tmo_param = ^32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= 4'b0000;
      owner_q       <= 2'd0;
      rr_ptr_q      <= 2'd0;
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      last_flag_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_vld_c) begin
            grant_q <= 4'b0001 << pick_c;
            owner_q <= pick_c;
            state_q <= GRANTED;
          end
        end
        GRANTED: begin
          if (xfer_c) begin
            tx_data_q   <= bus.req_data[{owner_q, 3'b000} +: 8];
            last_flag_q <= bus.req_last[owner_q];
            tx_start_q  <= 1'b1;
            state_q     <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
          end else if (!owner_vld_c) begin
            // Owner stalled mid-packet: revoke after TIMEOUT_CYCLES idle cycles.
            if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              tmo_cnt_q     <= '0;
              timeout_err_q <= 1'b1;
              grant_q       <= 4'b0000;
              rr_ptr_q      <= owner_q + 2'd1;
              state_q       <= IDLE;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end
`endif
          end
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (last_flag_q) begin
              grant_q  <= 4'b0000;
              rr_ptr_q <= owner_q + 2'd1;
              state_q  <= IDLE;
            end else begin
              state_q  <= GRANTED;
            end
          end
        end
        default: begin
          grant_q <= 4'b0000;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.grant     = grant_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random packet traffic
// checked against a packet-level round-robin model.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // UART model: busy for busy_len cycles starting the cycle after tx_start.
  logic uart_auto;
  logic busy_man;
  int   busy_len;
  int   busy_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            busy_cnt <= 0;
    else if (bus.tx_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = uart_auto ? (busy_cnt != 0) : busy_man;

  int vectors = 0;
  int miscompares = 0;

  int         n_start;
  logic [3:0] st_grant;
  logic [7:0] st_data;

  logic [7:0] q_dat [4][32];
  logic       q_lst [4][32];
  int         q_len [4];
  int         q_head[4];
  int         pos   [4];
  int         exp_own [128];
  logic [7:0] exp_dat [128];
  int         exp_n;
  int         model_rr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.tx_start) begin
      n_start++;
      st_grant = bus.grant;
      st_data  = bus.tx_data;
    end
  endtask

  task automatic clear_inputs();
    bus.req_valid = 4'b0000;
    bus.req_last  = 4'b0000;
    bus.req_data  = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 32'(bus.grant), 32'h0);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'h0);
    check({tag, "_start"}, 32'(bus.tx_start), 32'h0);
    check({tag, "_data"},  32'(bus.tx_data), 32'h0);
    check({tag, "_tmo"},   32'(bus.timeout_err), 32'h0);
  endtask

  task automatic do_reset();
    clear_inputs();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_rr = 0;
    n_start  = 0;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < 4; i++) begin
      q_len[i] = 0; q_head[i] = 0; pos[i] = 0;
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    q_dat[r][q_len[r]] = d;
    q_lst[r][q_len[r]] = l;
    q_len[r]++;
  endtask

  task automatic expect_byte(input int r, input logic [7:0] d);
    exp_own[exp_n] = r;
    exp_dat[exp_n] = d;
    exp_n++;
  endtask

  // Packet-level model: whole packets served one at a time, round-robin over pending requesters.
  task automatic build_expect();
    int h[4];
    int found;
    for (int i = 0; i < 4; i++) h[i] = q_head[i];
    exp_n = 0;
    for (int guard = 0; guard < 64; guard++) begin
      found = -1;
      for (int k = 0; k < 4; k++)
        if (found < 0 && h[(model_rr + k) % 4] < q_len[(model_rr + k) % 4]) found = (model_rr + k) % 4;
      if (found < 0) break;
      for (int b = 0; b < 32; b++) begin
        expect_byte(found, q_dat[found][h[found]]);
        h[found]++;
        if (q_lst[found][h[found] - 1]) break;
      end
      model_rr = (found + 1) % 4;
    end
  endtask

  // Presents queued bytes, pops on req_ready, checks each tx_start against the expected stream.
  task automatic run_engine(input bit bubbles, input int max_cycles);
    int idx = 0;
    int cyc = 0;
    while (idx < exp_n && cyc < max_cycles) begin
      tick();
      if (bus.tx_start) begin
        check("eng_owner", 32'(bus.grant), 32'(4'b0001 << exp_own[idx]));
        check("eng_data",  32'(bus.tx_data), 32'(exp_dat[idx]));
        idx++;
      end
      busy_len = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        if (q_head[i] < q_len[i] && !(bubbles && pos[i] > 0 && $urandom_range(0, 3) == 0)) begin
          bus.req_valid[i]        = 1'b1;
          bus.req_data[8*i +: 8]  = q_dat[i][q_head[i]];
          bus.req_last[i]         = q_lst[i][q_head[i]];
        end else begin
          bus.req_valid[i]        = 1'b0;
          bus.req_data[8*i +: 8]  = 8'($urandom);
          bus.req_last[i]         = 1'($urandom);
        end
      end
      #1;
      check("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'h1);
      for (int i = 0; i < 4; i++) begin
        if (bus.req_ready[i]) begin
          pos[i] = q_lst[i][q_head[i]] ? 0 : pos[i] + 1;
          q_head[i]++;
        end
      end
      cyc++;
    end
    check("eng_complete", 32'(idx), 32'(exp_n));
    clear_inputs();
    repeat (8) tick();
  endtask

  initial begin
    int t_pulse;
    int pulses;
    logic [3:0] g_hold;
    logic [3:0] g_after;

    rst_n = 1'b1;
    uart_auto = 1'b1;
    busy_man  = 1'b0;
    busy_len  = 3;
    clear_inputs();
    clear_queues();
    do_reset();

    // Single byte from requester 2.
    tick();
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h00A5_0000;
    bus.req_last  = 4'b0100;
    n_start = 0;
    tick();
    check("sb_grant", 32'(bus.grant), 32'h4);
    #1 check("sb_ready", 32'(bus.req_ready), 32'h4);
    tick();
    check("sb_start", 32'(bus.tx_start), 32'h1);
    check("sb_data",  32'(bus.tx_data), 32'hA5);
    clear_inputs();
    for (int k = 0; k < 50 && bus.grant != 4'b0000; k++) tick();
    check("sb_grant_clear", 32'(bus.grant), 32'h0);
    check("sb_one_pulse", 32'(n_start), 32'h1);
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    tick();
    tick();
    check("sb_rr_ptr3", 32'(bus.grant), 32'h8);

    // Round-robin with all four continuously valid.
    do_reset();
    clear_queues();
    exp_n = 0;
    for (int i = 0; i < 4; i++) push(i, 8'(8'h40 + i), 1'b1);
    push(0, 8'h50, 1'b1);
    expect_byte(0, 8'h40); expect_byte(1, 8'h41); expect_byte(2, 8'h42);
    expect_byte(3, 8'h43); expect_byte(0, 8'h50);
    run_engine(1'b0, 300);

    // Packet lock: requester 1 holds the grant for 3 bytes while requester 0 waits.
    do_reset();
    clear_queues();
    exp_n = 0;
    push(0, 8'h01, 1'b1);
    expect_byte(0, 8'h01);
    run_engine(1'b0, 100);
    clear_queues();
    exp_n = 0;
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h33, 1'b1);
    push(0, 8'h77, 1'b1);
    expect_byte(1, 8'h11); expect_byte(1, 8'h22); expect_byte(1, 8'h33); expect_byte(0, 8'h77);
    run_engine(1'b1, 400);

    // Random traffic against the round-robin packet model.
    do_reset();
    for (int round = 0; round < 8; round++) begin
      clear_queues();
      for (int i = 0; i < 4; i++) begin
        int npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          int nb = $urandom_range(1, 3);
          for (int b = 0; b < nb; b++) push(i, 8'($urandom), (b == nb - 1));
        end
      end
      build_expect();
      run_engine(1'b1, 3000);
    end

    // Busy hold-off: tx_busy high while granted blocks all transfers.
    do_reset();
    uart_auto = 1'b0;
    busy_man  = 1'b1;
    tick();
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h003C_0000;
    bus.req_last  = 4'b0100;
    n_start = 0;
    tick();
    for (int k = 0; k < 50; k++) begin
      #1 check("bh_ready", 32'(bus.req_ready), 32'h0);
      tick();
      check("bh_start", 32'(bus.tx_start), 32'h0);
    end
    busy_man = 1'b0;
    #1 check("bh_ready_release", 32'(bus.req_ready), 32'h4);
    tick();
    check("bh_start_release", 32'(bus.tx_start), 32'h1);
    check("bh_data", 32'(bus.tx_data), 32'h3C);
    clear_inputs();
    busy_man = 1'b1;
    repeat (2) tick();
    busy_man = 1'b0;
    repeat (3) tick();
    check("bh_grant_clear", 32'(bus.grant), 32'h0);
    uart_auto = 1'b1;

    // Reset during WAIT_DONE abandons the packet; requester 0 then wins.
    do_reset();
    busy_len = 10;
    tick();
    bus.req_valid = 4'b1000;
    bus.req_data  = 32'hC300_0000;
    bus.req_last  = 4'b0000;
    tick();
    tick();
    check("rm_start", 32'(bus.tx_start), 32'h1);
    clear_inputs();
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rm_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    bus.req_data  = 32'h4433_2211;
    busy_len = 2;
    n_start  = 0;
    for (int k = 0; k < 20 && n_start == 0; k++) tick();
    check("rm_first_owner", 32'(st_grant), 32'h1);
    check("rm_first_data",  32'(st_data), 32'h11);
    clear_inputs();
    repeat (12) tick();

    // Owner stalls mid-packet after one non-last byte.
    do_reset();
    busy_len = 2;
    tick();
    bus.req_valid = 4'b0010;
    bus.req_data  = 32'h0000_5A00;
    bus.req_last  = 4'b0000;
    tick();
    tick();
    check("to_start", 32'(bus.tx_start), 32'h1);
    bus.req_valid = 4'b0100;
    bus.req_last  = 4'b0100;
    pulses = 0; t_pulse = -1; g_hold = 4'b0000; g_after = 4'b0000;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (bus.timeout_err) begin
        pulses++;
        if (t_pulse < 0) t_pulse = t;
      end
      if (t == 19) g_hold = bus.grant;
      if (t_pulse > 0 && t == t_pulse + 1) g_after = bus.grant;
      if (t == 30 && t_pulse < 0) g_after = bus.grant;
    end
    check("to_grant_held", 32'(g_hold), 32'h2);
`ifdef UART_ARB_TIMEOUT_EN
    check("to_pulses", 32'(pulses), 32'h1);
    check("to_pulse_time", 32'(t_pulse), 32'd20);
    check("to_next_owner", 32'(g_after), 32'h4);
`else
    check("to_no_pulse", 32'(pulses), 32'h0);
    check("to_grant_kept", 32'(g_after), 32'h2);
`endif

    clear_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1024, number of idle cycles a granted requester may stall mid-packet before its grant is revoked (used only with UART_ARB_TIMEOUT_EN).
REQ-002 Port: clk  input  1  system clock; single clock domain for the whole block.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  4  per-requester byte-valid; bit i belongs to requester i.
REQ-005 Port: req_data  input  32  packed bytes; requester i at [8i+7:8i].
REQ-006 Port: req_last  input  4  per-requester last-byte-of-packet flag, qualified by req_valid.
REQ-007 Port: req_ready  output  4  per-requester accept strobe; at most one bit high.
REQ-008 Port: grant  output  4  one-hot owner of the UART transmitter; all-zero when unowned.
REQ-009 Port: tx_data  output  8  byte presented to the UART transmitter.
REQ-010 Port: tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-011 Port: tx_busy  input  1  UART transmitter busy; high from the cycle after tx_start until the stop bit completes.
REQ-012 Port: timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-013 The FSM SHALL have states IDLE, GRANTED, WAIT_BUSY and WAIT_DONE; any other encoding SHALL return to IDLE.
REQ-014 IDLE: if any req_valid bit is high, the FSM SHALL set grant one-hot to the first valid requester, searching round-robin from rr_ptr upward with wrap 3->0, and SHALL enter GRANTED on the next edge (one-cycle grant latency).
REQ-015 GRANTED: req_ready[g] SHALL be driven combinationally as req_valid[g] AND NOT tx_busy; all other req_ready bits SHALL be 0.
REQ-016 On a transfer (req_valid[g] and req_ready[g] high on the same edge), the block SHALL register tx_data from req_data lane g, store req_last[g] as last_flag, assert tx_start for exactly one cycle, and enter WAIT_BUSY.
REQ-017 WAIT_BUSY: tx_start SHALL be 0, and the FSM SHALL move to WAIT_DONE on the first cycle tx_busy is 1.
REQ-018 WAIT_DONE: on the first cycle tx_busy is 0, the FSM SHALL enter IDLE if last_flag is 1, otherwise GRANTED.
REQ-019 On entering IDLE from WAIT_DONE, the block SHALL clear grant and set rr_ptr to (g+1) mod 4.
REQ-020 Grant SHALL be held for the whole packet; no other requester is served until last_flag completes, even if the owner drops req_valid.
REQ-021 Requests arriving while a grant is held SHALL be ignored until the next IDLE arbitration; simultaneous requests SHALL be resolved purely by rr_ptr.
REQ-022 If tx_busy is already high in GRANTED, no transfer SHALL occur until it falls.

Reset
REQ-023 While rst_n is 0, regardless of clk: state SHALL be IDLE; grant, req_ready, tx_start, timeout_err SHALL be 0; tx_data SHALL be 8'h00; rr_ptr SHALL be 0; last_flag and the timeout counter SHALL be 0.
REQ-024 A reset mid-packet SHALL abandon the packet; no tx_start SHALL be issued after reset release until a new transfer per REQ-016.

Configuration
REQ-025 With macro UART_ARB_TIMEOUT_EN defined, a counter SHALL increment each GRANTED cycle with req_valid[g]=0, clear on any transfer, and at TIMEOUT_CYCLES SHALL force IDLE, clear grant, set rr_ptr=(g+1) mod 4 and pulse timeout_err for one cycle.
REQ-026 With UART_ARB_TIMEOUT_EN undefined, no counter SHALL be built, the grant SHALL be held indefinitely, and timeout_err SHALL be tied to 0.

Verification
REQ-027 Single byte: req_valid=4'b0100, data lane2=8'hA5, last=1 -> grant=4'b0100 one cycle later; tx_start is one pulse with tx_data=8'hA5; grant clears after tx_busy falls; rr_ptr=3.
REQ-028 Round-robin: all four requesters continuously valid, one-byte packets -> grant order 0,1,2,3,0.
REQ-029 Packet lock: requester 1 sends 3 bytes 8'h11,8'h22,8'h33 (last on 3rd) while requester 0 is valid -> all three bytes sent before grant moves to 0.
REQ-030 Busy hold-off: tx_busy forced high in GRANTED for 50 cycles -> req_ready stays 0 and tx_start stays 0 until tx_busy falls.
REQ-031 Reset mid-packet: rst_n pulled low during WAIT_DONE -> all outputs 0 asynchronously; after release, requester 0 wins simultaneous requests.
REQ-032 Timeout (macro defined, TIMEOUT_CYCLES=16): owner sends one non-last byte and then drops valid -> after 16 idle cycles, timeout_err pulses once and grant passes to the next valid requester.
